// File: rtl/video_ramp_source_if.sv
// AXI4-Stream video bus carrying one 64-bit pixel beat with SOF (tuser) and EOL (tlast).
interface video_ramp_source_if;
  logic [63:0] tdata;
  logic        tvalid;
  logic        tready;
  logic        tuser;
  logic        tlast;

  modport master (output tdata, output tvalid, output tuser, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tuser, input tlast, output tready);
endinterface

// File: rtl/video_ramp_source.sv
// Colour-ramp AXI4-Stream frame generator with SOF/EOL framing, inter-frame gap and backpressure.
module video_ramp_source #(
  parameter int unsigned H_ACTIVE  = 1920,
  parameter int unsigned V_ACTIVE  = 1080,
  parameter int unsigned FRAME_GAP = 16,
  parameter logic [23:0] SEED_RGB  = 24'hFFFFFF
) (
  input  logic                       aclk,
  input  logic                       areset,
  input  logic                       aclken,
  input  logic                       enable,
  video_ramp_source_if.master        m_axis_video,
  output logic                       frame_done,
  output logic [15:0]                frame_count
);

  localparam int unsigned XW = $clog2(H_ACTIVE);
  localparam int unsigned YW = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
  localparam int unsigned GW = $clog2(FRAME_GAP + 2);
  localparam logic [XW-1:0] X_LAST = XW'(H_ACTIVE - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(V_ACTIVE - 1);
  localparam logic [GW-1:0] G_LAST = GW'((FRAME_GAP > 0) ? FRAME_GAP - 1 : 0);

  typedef enum logic [1:0] {S_IDLE, S_STREAM, S_GAP} state_e;

  state_e         state_q, state_d;
  logic [XW-1:0]  x_q, x_d;
  logic [YW-1:0]  y_q, y_d;
  logic [7:0]     r_q, r_d, g_q, g_d, b_q, b_d;
  logic [GW-1:0]  gap_q, gap_d;
  logic           tvalid_q, tvalid_d;
  logic           tuser_q, tuser_d;
  logic           tlast_q, tlast_d;
  logic [63:0]    tdata_q, tdata_d;
  logic           frame_done_q, frame_done_d;
  logic [15:0]    frame_count_q, frame_count_d;
  logic           accept_c, start_frame_c, check_enable_c;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q       <= S_IDLE;
      x_q           <= '0;
      y_q           <= '0;
      r_q           <= SEED_RGB[23:16];
      g_q           <= SEED_RGB[15:8];
      b_q           <= SEED_RGB[7:0];
      gap_q         <= '0;
      tvalid_q      <= 1'b0;
      tuser_q       <= 1'b0;
      tlast_q       <= 1'b0;
      tdata_q       <= '0;
      frame_done_q  <= 1'b0;
      frame_count_q <= '0;
    end else begin
      state_q       <= state_d;
      x_q           <= x_d;
      y_q           <= y_d;
      r_q           <= r_d;
      g_q           <= g_d;
      b_q           <= b_d;
      gap_q         <= gap_d;
      tvalid_q      <= tvalid_d;
      tuser_q       <= tuser_d;
      tlast_q       <= tlast_d;
      tdata_q       <= tdata_d;
      frame_done_q  <= frame_done_d;
      frame_count_q <= frame_count_d;
    end
  end

  // frame_done is a one-aclk pulse even when aclken drops right after it fires
  always_comb begin
    state_d        = state_q;
    x_d            = x_q;
    y_d            = y_q;
    r_d            = r_q;
    g_d            = g_q;
    b_d            = b_q;
    gap_d          = gap_q;
    tvalid_d       = tvalid_q;
    tuser_d        = tuser_q;
    tlast_d        = tlast_q;
    frame_done_d   = 1'b0;
    frame_count_d  = frame_count_q;
    accept_c       = tvalid_q & m_axis_video.tready;
    start_frame_c  = 1'b0;
    check_enable_c = 1'b0;
    tdata_d        = '0;

    if (aclken) begin
      case (state_q)
        S_IDLE: start_frame_c = enable;
        S_STREAM: begin
          if (accept_c) begin
            if (x_q == X_LAST && y_q == Y_LAST) begin
              frame_done_d  = 1'b1;
              frame_count_d = frame_count_q + 16'd1;
              x_d           = '0;
              y_d           = '0;
              if (FRAME_GAP > 0) begin
                state_d  = S_GAP;
                gap_d    = '0;
                tvalid_d = 1'b0;
                tuser_d  = 1'b0;
                tlast_d  = 1'b0;
              end else begin
                check_enable_c = 1'b1;
              end
            end else begin
              x_d     = (x_q == X_LAST) ? '0 : x_q + XW'(1);
              y_d     = (x_q == X_LAST) ? y_q + YW'(1) : y_q;
              r_d     = r_q - 8'd1;
              g_d     = g_q + 8'd1;
              b_d     = b_q - 8'd2;
              tuser_d = 1'b0;
              tlast_d = (x_d == X_LAST);
            end
          end
        end
        S_GAP: begin
          gap_d          = gap_q + GW'(1);
          check_enable_c = (gap_q == G_LAST);
        end
        default: state_d = S_IDLE;
      endcase

      if (check_enable_c) begin
        if (enable) begin
          start_frame_c = 1'b1;
        end else begin
          state_d  = S_IDLE;
          tvalid_d = 1'b0;
          tuser_d  = 1'b0;
          tlast_d  = 1'b0;
        end
      end

      // Every frame starts from the seed colour at (0,0)
      if (start_frame_c) begin
        state_d  = S_STREAM;
        tvalid_d = 1'b1;
        tuser_d  = 1'b1;
        tlast_d  = 1'b0;
        x_d      = '0;
        y_d      = '0;
        r_d      = SEED_RGB[23:16];
        g_d      = SEED_RGB[15:8];
        b_d      = SEED_RGB[7:0];
      end
    end

    if (tvalid_d) begin
      tdata_d[29:22] = r_d;
      tdata_d[19:12] = b_d;
      tdata_d[9:2]   = g_d;
    end
  end

  assign m_axis_video.tdata  = tdata_q;
  assign m_axis_video.tvalid = tvalid_q;
  assign m_axis_video.tuser  = tuser_q;
  assign m_axis_video.tlast  = tlast_q;
  assign frame_done          = frame_done_q;
  assign frame_count         = frame_count_q;

endmodule
